// File: rtl/match_pkg.sv
// Shared types, default parameters and width helpers for the tug-of-war
// match sequencer.
package match_pkg;

    typedef enum logic [1:0] {
        M_IDLE,
        M_PLAY,
        M_PAUSE,
        M_OVER
    } match_state_t;

    localparam int WIN_SCORE_DEF    = 7;
    localparam int SCORE_W_DEF      = 3;
    localparam int PAUSE_CYCLES_DEF = 4;

    // Wide enough to hold PAUSE_CYCLES itself, so a load of PAUSE_CYCLES-1 always fits.
    function automatic int pause_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/score_counter.sv
// One player's round-win counter; saturates at WIN_SCORE and flags the
// round win that would take the match.
module score_counter
    import match_pkg::*;
#(
    parameter int SCORE_W   = SCORE_W_DEF,
    parameter int WIN_SCORE = WIN_SCORE_DEF
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               clear,
    input  logic               inc,
    output logic [SCORE_W-1:0] count,
    output logic               at_target
);

    // One extra bit so count+1 cannot wrap before the comparison.
    localparam logic [SCORE_W:0] TARGET = (SCORE_W + 1)'(WIN_SCORE);

    logic [SCORE_W:0] count_ext;

    assign count_ext = {1'b0, count};
    assign at_target = (count_ext + (SCORE_W + 1)'(1)) == TARGET;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (Reset || clear) begin
            count <= '0;
        end else if (inc && (count_ext < TARGET)) begin
            count <= count + SCORE_W'(1);
        end
    end

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer: gates play, holds the round datapath in reset for a
// fixed pause between rounds, and declares the match winner.
module match_controller
    import match_pkg::*;
#(
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int SCORE_W      = SCORE_W_DEF,
    parameter int PAUSE_CYCLES = PAUSE_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               start,
    input  logic               leftWon,
    input  logic               rightWon,
    output logic               playEnable,
    output logic               roundReset,
    output logic [SCORE_W-1:0] leftScore,
    output logic [SCORE_W-1:0] rightScore,
    output logic               leftMatch,
    output logic               rightMatch
);

    localparam int                 PAUSE_W    = pause_cnt_w(PAUSE_CYCLES);
    localparam logic [PAUSE_W-1:0] PAUSE_LOAD = PAUSE_W'(PAUSE_CYCLES - 1);

    match_state_t       state;
    logic [PAUSE_W-1:0] pause_cnt;
    logic               left_point;
    logic               right_point;
    logic               score_clear;
    logic               left_at_target;
    logic               right_at_target;

    // A simultaneous win is a tie and scores nothing.
    assign left_point  = (state == M_PLAY) && leftWon && !rightWon;
    assign right_point = (state == M_PLAY) && rightWon && !leftWon;
    assign score_clear = (state == M_OVER) && start;

    score_counter #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)) u_left (
        .clk       (clk),
        .Reset     (Reset),
        .clear     (score_clear),
        .inc       (left_point),
        .count     (leftScore),
        .at_target (left_at_target)
    );

    score_counter #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)) u_right (
        .clk       (clk),
        .Reset     (Reset),
        .clear     (score_clear),
        .inc       (right_point),
        .count     (rightScore),
        .at_target (right_at_target)
    );

    // Outputs are set alongside each transition so they track the next state.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state      <= M_IDLE;
            pause_cnt  <= '0;
            playEnable <= 1'b0;
            roundReset <= 1'b1;
            leftMatch  <= 1'b0;
            rightMatch <= 1'b0;
        end else begin
            unique case (state)
                M_IDLE: begin
                    if (start) begin
                        state      <= M_PLAY;
                        playEnable <= 1'b1;
                        roundReset <= 1'b0;
                    end
                end
                M_PLAY: begin
                    if (left_point || right_point) begin
                        playEnable <= 1'b0;
                        roundReset <= 1'b1;
                        if (left_point && left_at_target) begin
                            state     <= M_OVER;
                            leftMatch <= 1'b1;
                        end else if (right_point && right_at_target) begin
                            state      <= M_OVER;
                            rightMatch <= 1'b1;
                        end else begin
                            state     <= M_PAUSE;
                            pause_cnt <= PAUSE_LOAD;
                        end
                    end
                end
                M_PAUSE: begin
                    if (pause_cnt == '0) begin
                        state      <= M_PLAY;
                        playEnable <= 1'b1;
                        roundReset <= 1'b0;
                    end else begin
                        pause_cnt <= pause_cnt - PAUSE_W'(1);
                    end
                end
                M_OVER: begin
                    if (start) begin
                        state      <= M_PLAY;
                        playEnable <= 1'b1;
                        roundReset <= 1'b0;
                        leftMatch  <= 1'b0;
                        rightMatch <= 1'b0;
                    end
                end
                default: state <= M_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: a behavioural match model is compared
// every cycle, plus literal expectations at the key points of each scenario.
module tb_match_controller;

    localparam int WIN   = 3;
    localparam int SW    = 3;
    localparam int PAUSE = 4;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          start = 1'b0;
    logic          leftWon = 1'b0;
    logic          rightWon = 1'b0;
    logic          playEnable;
    logic          roundReset;
    logic [SW-1:0] leftScore;
    logic [SW-1:0] rightScore;
    logic          leftMatch;
    logic          rightMatch;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Match model: scores, whether a round is live, remaining pause cycles.
    int m_l = 0;
    int m_r = 0;
    bit m_lm = 1'b0;
    bit m_rm = 1'b0;
    bit m_playing = 1'b0;
    bit m_over = 1'b0;
    int m_pause_left = 0;

    match_controller #(.WIN_SCORE(WIN), .SCORE_W(SW), .PAUSE_CYCLES(PAUSE)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .start      (start),
        .leftWon    (leftWon),
        .rightWon   (rightWon),
        .playEnable (playEnable),
        .roundReset (roundReset),
        .leftScore  (leftScore),
        .rightScore (rightScore),
        .leftMatch  (leftMatch),
        .rightMatch (rightMatch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (Reset) begin
            m_l <= 0; m_r <= 0; m_lm <= 1'b0; m_rm <= 1'b0;
            m_playing <= 1'b0; m_over <= 1'b0; m_pause_left <= 0;
        end else if (m_over) begin
            if (start) begin
                m_l <= 0; m_r <= 0; m_lm <= 1'b0; m_rm <= 1'b0;
                m_over <= 1'b0; m_playing <= 1'b1;
            end
        end else if (m_pause_left > 0) begin
            m_pause_left <= m_pause_left - 1;
            if (m_pause_left == 1) m_playing <= 1'b1;
        end else if (m_playing) begin
            if (leftWon != rightWon) begin
                m_playing <= 1'b0;
                if (leftWon) begin
                    m_l <= m_l + 1;
                    if (m_l + 1 == WIN) begin m_over <= 1'b1; m_lm <= 1'b1; end
                    else m_pause_left <= PAUSE;
                end else begin
                    m_r <= m_r + 1;
                    if (m_r + 1 == WIN) begin m_over <= 1'b1; m_rm <= 1'b1; end
                    else m_pause_left <= PAUSE;
                end
            end
        end else if (start) begin
            m_playing <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_playEnable", int'(playEnable), int'(m_playing));
            check("model_roundReset", int'(roundReset), int'(!m_playing));
            check("model_leftScore", int'(leftScore), m_l);
            check("model_rightScore", int'(rightScore), m_r);
            check("model_leftMatch", int'(leftMatch), int'(m_lm));
            check("model_rightMatch", int'(rightMatch), int'(m_rm));
        end
    end

    task automatic cyc(input bit rst, input bit st, input bit l, input bit r);
        Reset = rst; start = st; leftWon = l; rightWon = r;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_play();
        int n = 0;
        while (!playEnable && n < 20) begin
            cyc(0, 0, 0, 0);
            n++;
        end
        check("wait_play", int'(playEnable), 1);
    endtask

    task automatic expect_all(input string name, input int pe, input int rr,
                              input int ls, input int rs, input int lm, input int rm);
        check({name, "_pe"}, int'(playEnable), pe);
        check({name, "_rr"}, int'(roundReset), rr);
        check({name, "_ls"}, int'(leftScore), ls);
        check({name, "_rs"}, int'(rightScore), rs);
        check({name, "_lm"}, int'(leftMatch), lm);
        check({name, "_rm"}, int'(rightMatch), rm);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // 1: reset then idle without start
        cyc(1, 0, 0, 0);
        chk_en = 1'b1;
        cyc(1, 0, 0, 0);
        expect_all("reset", 0, 1, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0);
        expect_all("idle_hold", 0, 1, 0, 0, 0, 0);

        // 2: start, left round win, pause length
        cyc(0, 1, 0, 0);
        expect_all("start", 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        expect_all("left_win1", 0, 1, 1, 0, 0, 0);
        n = 0;
        while (roundReset && n < 20) begin
            n++;
            cyc(0, 0, 0, 0);
        end
        check("pause_len", n, PAUSE);
        check("pause_resume_pe", int'(playEnable), 1);

        // 3: tie, held right win, start in PLAY, left pulse inside pause
        cyc(0, 0, 1, 1);
        expect_all("tie", 1, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        expect_all("start_in_play", 1, 0, 1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 1);
        cyc(0, 1, 1, 0);
        expect_all("held_right", 0, 1, 1, 1, 0, 0);
        wait_play();

        // 4: right takes the match, then wins are ignored in OVER
        cyc(0, 0, 0, 1);
        wait_play();
        cyc(0, 0, 0, 1);
        expect_all("right_match", 0, 1, 1, 3, 0, 1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);
        expect_all("over_hold", 0, 1, 1, 3, 0, 1);

        // 5: restart from OVER
        cyc(0, 1, 0, 0);
        expect_all("restart", 1, 0, 0, 0, 0, 0);

        // 6: reset on the 2nd pause cycle with leftScore=2
        cyc(0, 0, 1, 0);
        wait_play();
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        expect_all("pre_reset", 0, 1, 2, 0, 0, 0);
        cyc(1, 0, 0, 0);
        expect_all("mid_pause_reset", 0, 1, 0, 0, 0, 0);
        repeat (6) cyc(0, 0, 0, 0);
        expect_all("no_resume", 0, 1, 0, 0, 0, 0);

        // left takes a match for the other flag
        cyc(0, 1, 0, 0);
        for (int i = 0; i < WIN - 1; i++) begin
            cyc(0, 0, 1, 0);
            wait_play();
        end
        cyc(0, 0, 1, 0);
        expect_all("left_match", 0, 1, 3, 0, 1, 0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
